// File: rtl/bus_byte_fifo_pkg.sv
// Shared defaults and operation encoding for the bus-side byte FIFO.
package bus_byte_fifo_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_DEPTH  = 4;
  localparam int DEF_ADDR_W = 2;

  // Encoded as {write_accepted, read_accepted}.
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/bus_byte_fifo_ptr.sv
// Modulo-DEPTH pointer register; DEPTH is a power of two, so wrap is the natural carry-out.
module fifo_ptr #(
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  output logic [ADDR_W-1:0] ptr
);

  logic [ADDR_W-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + ADDR_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/bus_byte_fifo.sv
// Byte FIFO feeding a 74x541 bus buffer; head on q, active-low buffer enable on noe.
// Optional sticky overrun flag on rejected writes when BUS_FIFO_OVERRUN_EN is defined.
module bus_byte_fifo
  import bus_byte_fifo_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              wr,
  input  logic              rd,
  input  logic              nsel,
  output logic [WIDTH-1:0]  q,
  output logic              noe,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
`ifdef BUS_FIFO_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  localparam int CNT_W = ADDR_W + 1;

  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [ADDR_W-1:0] rptr, wptr;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              empty_q, empty_d, full_q, full_d;
  logic              wr_acc, rd_acc;
  fifo_op_e          op;

  // A full FIFO still takes a write when a read frees the head slot in the same cycle.
  always_comb begin
    wr_acc  = wr && (!full_q || rd);
    rd_acc  = rd && !empty_q;
    op      = fifo_op_e'({wr_acc, rd_acc});
    count_d = count_q;
    case (op)
      OP_WR:   count_d = count_q + CNT_W'(1);
      OP_RD:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= empty_d;
      full_q  <= full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wptr] <= wdata;
  end

  fifo_ptr #(.ADDR_W(ADDR_W)) u_rptr (
    .clk   (clk),
    .reset (reset),
    .inc   (rd_acc),
    .ptr   (rptr)
  );

  fifo_ptr #(.ADDR_W(ADDR_W)) u_wptr (
    .clk   (clk),
    .reset (reset),
    .inc   (wr_acc),
    .ptr   (wptr)
  );

  assign q     = empty_q ? '0 : mem_q[rptr];
  assign noe   = nsel | empty_q;
  assign empty = empty_q;
  assign full  = full_q;
  assign count = count_q;

`ifdef BUS_FIFO_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge clk) begin
    if (reset)                      overrun_q <= 1'b0;
    else if (wr && full_q && !rd)   overrun_q <= 1'b1;
  end

  assign overrun = overrun_q;
`endif

endmodule
